// File: rtl/ha_seq_pkg.sv
// ---------------------------------------------------------------------------
// ha_seq_pkg
//   Shared definitions for the bit-serial half-adder sequencer.
//   ha_state_e       : controller state encoding (IDLE, PASS1, PASS2, DONE)
//   HA_DEFAULT_WIDTH : default operand/sum width
// ---------------------------------------------------------------------------
package ha_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS1 = 2'd1,
    PASS2 = 2'd2,
    DONE  = 2'd3
  } ha_state_e;

  localparam int unsigned HA_DEFAULT_WIDTH = 8;

endpackage : ha_seq_pkg

// File: rtl/ha_serial_adder_ctrl_half_adder.sv
// ---------------------------------------------------------------------------
// half_adder
//   Single-bit half adder, time-shared by the serial adder controller.
//   a, b : operand bits
//   s    : sum bit   (a ^ b)
//   c    : carry bit (a & b)
// ---------------------------------------------------------------------------
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule : half_adder

// File: rtl/ha_serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// ha_serial_adder_ctrl
//   Bit-serial WIDTH-bit ripple adder built around one shared half adder.
//   Each bit takes two cycles: an operand pass (a[i], b[i]) and a carry pass
//   (partial sum, running carry). Result is published with a done pulse.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   ena   : design enable; low freezes all state
//   start : request, accepted only in IDLE
//   a, b  : operands, sampled on the accepting edge
//   cin   : carry-in, sampled on the accepting edge
//   busy  : high in PASS1/PASS2
//   done  : one-cycle completion pulse
//   sum   : last completed sum
//   cout  : last completed carry-out
// ---------------------------------------------------------------------------
module ha_serial_adder_ctrl
  import ha_seq_pkg::*;
#(
  parameter int unsigned WIDTH = HA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

  ha_state_e        state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             c1_q, c1_d;
  logic             s1_q, s1_d;
  logic             cout_q, cout_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic ha_a, ha_b, ha_s, ha_c;

  // Operand mux: the carry pass re-uses the adder for partial sum + carry.
  always_comb begin
    ha_a = a_q[idx_q];
    ha_b = b_q[idx_q];
    if (state_q == PASS2) begin
      ha_a = s1_q;
      ha_b = carry_q;
    end
  end

  half_adder u_ha (
    .a (ha_a),
    .b (ha_b),
    .s (ha_s),
    .c (ha_c)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    c1_d    = c1_q;
    s1_d    = s1_q;
    cout_d  = cout_q;
    idx_d   = idx_q;
    if (ena) begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            a_d     = a;
            b_d     = b;
            carry_d = cin;
            idx_d   = '0;
            state_d = PASS1;
          end
        end
        PASS1: begin
          s1_d    = ha_s;
          c1_d    = ha_c;
          state_d = PASS2;
        end
        PASS2: begin
          acc_d[idx_q] = ha_s;
          // Both half-adder carries cannot be set together, so OR is exact.
          carry_d      = ha_c | c1_q;
          if (idx_q == IDX_LAST) begin
            sum_d   = acc_d;
            cout_d  = carry_d;
            state_d = DONE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = PASS1;
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      c1_q    <= 1'b0;
      s1_q    <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      c1_q    <= c1_d;
      s1_q    <= s1_d;
      cout_q  <= cout_d;
      idx_q   <= idx_d;
    end
  end

  assign busy = (state_q == PASS1) || (state_q == PASS2);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule : ha_serial_adder_ctrl

// File: tb/tb_ha_serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ha_serial_adder_ctrl
//   Directed-vector bench for the 8-bit bit-serial adder sequencer.
// ---------------------------------------------------------------------------
module tb_ha_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         ena;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int total;
  int bad;

  ha_serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic         vcin;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Accept a request at the next rising edge (edge N), then scramble the
  // operand inputs right after it; they must be don't-care from here on.
  task automatic start_op(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc);
    @(negedge clk);
    a     = va;
    b     = vb;
    cin   = vc;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = '1;
    b     = '1;
    cin   = 1'b1;
  endtask

  // Sample at each falling edge after edge N+k; returns k of the first done.
  // pulse_k: drive a stray start sampled at edge N+pulse_k+1.
  // lo_k/hi_k: drop ena at sample lo_k, raise it again at sample hi_k.
  task automatic wait_done(input int pulse_k, input int lo_k, input int hi_k,
                           output int cycles, output int bcnt);
    int k;
    logic [W-1:0] frz_sum;
    k       = 0;
    bcnt    = 0;
    cycles  = -1;
    frz_sum = '0;
    while (k <= 100) begin
      @(negedge clk);
      check("busy_done_exclusive", {31'd0, busy & done}, 32'd0);
      if (lo_k >= 0 && k > lo_k && k <= hi_k) begin
        check("frozen_busy", {31'd0, busy}, 32'd1);
        check("frozen_done", {31'd0, done}, 32'd0);
        check("frozen_sum", {24'd0, sum}, {24'd0, frz_sum});
      end
      if (k == pulse_k) begin
        start = 1'b1;
        a     = 8'hFF;
        b     = 8'hFF;
      end else begin
        start = 1'b0;
      end
      if (k == lo_k) begin
        ena     = 1'b0;
        frz_sum = sum;
      end
      if (k == hi_k) ena = 1'b1;
      if (done) begin
        cycles = k;
        break;
      end
      if (busy) bcnt++;
      k++;
    end
    if (cycles < 0) begin
      bad++;
      total++;
      $display("FAIL done_timeout: got=no done expected=done within 100 cycles");
    end
  endtask

  initial begin
    int cyc;
    int bc;
    logic seen;
    total = 0;
    bad   = 0;

    vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'h3C, 8'h42, 1'b0, 8'h7E, 1'b0};
    vecs[3] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
    vecs[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[6] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};

    rst_n = 1'b0;
    ena   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_sum", {24'd0, sum}, 32'd0);
    check("reset_cout", {31'd0, cout}, 32'd0);

    // Table-driven additions: latency, busy length, single done, result.
    for (int i = 0; i < 7; i++) begin
      start_op(vecs[i].va, vecs[i].vb, vecs[i].vcin);
      wait_done(-1, -1, -1, cyc, bc);
      check("vec_done_cycle", cyc, 2 * W);
      check("vec_busy_cycles", bc, 2 * W);
      check("vec_sum", {24'd0, sum}, {24'd0, vecs[i].exp_sum});
      check("vec_cout", {31'd0, cout}, {31'd0, vecs[i].exp_cout});
      @(negedge clk);
      check("vec_done_single", {31'd0, done}, 32'd0);
      check("vec_idle_busy", {31'd0, busy}, 32'd0);
    end

    // Stray start pulses mid-operation (edge N+5) and in DONE are ignored.
    start_op(8'h10, 8'h20, 1'b0);
    wait_done(4, -1, -1, cyc, bc);
    check("ign_done_cycle", cyc, 2 * W);
    check("ign_sum", {24'd0, sum}, 32'h30);
    check("ign_cout", {31'd0, cout}, 32'd0);
    start = 1'b1;
    a     = 8'h77;
    b     = 8'h11;
    @(negedge clk);
    start = 1'b0;
    check("ign_done_state_busy", {31'd0, busy}, 32'd0);
    check("ign_done_state_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    check("ign_still_idle", {31'd0, busy}, 32'd0);
    check("ign_sum_hold", {24'd0, sum}, 32'h30);

    // Three ena-low cycles stretch latency by three.
    start_op(8'h7F, 8'h01, 1'b0);
    wait_done(-1, 3, 6, cyc, bc);
    check("ena_done_cycle", cyc, 2 * W + 3);
    check("ena_busy_cycles", bc, 2 * W + 3);
    check("ena_sum", {24'd0, sum}, 32'h80);
    check("ena_cout", {31'd0, cout}, 32'd0);
    @(negedge clk);

    // Mid-operation reset aborts and clears results asynchronously.
    start_op(8'hFF, 8'hFF, 1'b0);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_sum", {24'd0, sum}, 32'd0);
    check("abort_cout", {31'd0, cout}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 1'b0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    check("abort_no_activity", {31'd0, seen}, 32'd0);
    start_op(8'hFF, 8'hFF, 1'b0);
    wait_done(-1, -1, -1, cyc, bc);
    check("fresh_done_cycle", cyc, 2 * W);
    check("fresh_sum", {24'd0, sum}, 32'hFE);
    check("fresh_cout", {31'd0, cout}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_ha_serial_adder_ctrl

// File: doc/ha_serial_adder_ctrl.md
# ha_serial_adder_ctrl

Sequencer that time-shares one `half_adder` instance to perform a WIDTH-bit ripple addition bit-serially.
- Each bit is computed in two passes through the shared half adder: operand pass, then carry pass.
- Sits inside the Tiny Tapeout user project, behind the `ui_in`/`uio_in` pins, as the next step up from the single half-adder datapath.
- Delivers sum and carry-out with a start/busy/done handshake.

## Interface
- `WIDTH`, default 8: operand and sum width; must be ≥ 2.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `ena`  in  1  design enable; when low, all state and outputs hold.
- `start`  in  1  request; accepted only in IDLE with `ena`=1.
- `a`  in  WIDTH  operand A; sampled on the accepting edge.
- `b`  in  WIDTH  operand B; sampled on the accepting edge.
- `cin`  in  1  carry-in; sampled on the accepting edge.
- `busy`  out  1  high while in PASS1/PASS2.
- `done`  out  1  single-cycle completion pulse (state DONE).
- `sum`  out  WIDTH  result register; holds the last completed result.
- `cout`  out  1  carry-out of the last completed result.

## Operation
- State machine: IDLE, PASS1, PASS2, DONE. Registers: `a_q`, `b_q`, `acc_q`, `carry_q`, `c1_q`, `s1_q`, `idx_q` (width $clog2(WIDTH)).
- IDLE:
  - On `start`: capture `a`, `b`, `cin` into `a_q`, `b_q`, `carry_q`; clear `idx_q`; go to PASS1.
  - Otherwise stay in IDLE.
- PASS1:
  - Drive the half adder with `a_q[idx]`, `b_q[idx]`.
  - Register its outputs into `s1_q`, `c1_q`; go to PASS2.
- PASS2:
  - Drive the half adder with `s1_q`, `carry_q`.
  - Write the HA sum to `acc_q[idx]`; set `carry_q` = HA carry OR `c1_q`.
  - If `idx_q` = WIDTH-1: copy `acc_q` (with the new bit) to `sum` and the final carry to `cout`, then go to DONE.
  - Otherwise increment `idx_q` and go to PASS1.
- DONE: `done`=1 for one cycle, then IDLE. `start` is ignored in DONE.
- `start` while busy or in DONE is ignored; no queueing.
- Operand inputs are don't-care after the accepting edge.
- `ena`=0: FSM, counters and registers freeze and outputs hold; a pending `start` is not accepted.
- Arithmetic: unsigned modulo 2^WIDTH; `cout` is bit WIDTH of `a + b + cin`.

## Timing
- Reset (async assert, sync release): state IDLE; `busy`=0, `done`=0, `sum`=0, `cout`=0; all internal registers 0.
- `start` accepted at edge N, with `ena` continuously high:
  - `busy`=1 from N to N+2·WIDTH.
  - `done`=1 between edges N+2·WIDTH and N+2·WIDTH+1.
  - `sum`/`cout` update at edge N+2·WIDTH.
- Earliest next accept is edge N+2·WIDTH+2 (IDLE reached at N+2·WIDTH+1).
- Each `ena`-low cycle extends latency by exactly one cycle.
- `busy` and `done` are never high together. Both are combinational decodes of the registered state; no input-to-output combinational path.
- Reset mid-operation aborts the operation: no `done` pulse, and `sum`/`cout` clear to 0.

## Structure
- Package `ha_seq_pkg`: state enum `ha_state_e` (IDLE, PASS1, PASS2, DONE), localparam `HA_DEFAULT_WIDTH` = 8.
- Sub-module `half_adder` (a, b → s = a^b, c = a&b), instantiated exactly once. The controller's operand muxes select its inputs per state.
- No other hierarchy.

## Test plan
- Reset, then `a`=8'h00, `b`=8'h00, `cin`=0 → `sum`=8'h00, `cout`=0; `done` exactly at N+16 for one cycle; `busy` high for 16 cycles.
- `a`=8'hFF, `b`=8'h01, `cin`=0 → `sum`=8'h00, `cout`=1. Then `a`=8'h3C, `b`=8'h42, `cin`=0 → `sum`=8'h7E, `cout`=0.
- `a`=8'hA5, `b`=8'h5A, `cin`=1 → `sum`=8'h00, `cout`=1. Change `a`/`b` to 8'hFF immediately after accept → result unchanged.
- Start 8'h10+8'h20, then pulse `start` with other operands at N+5 and in DONE → ignored; single `done`; `sum`=8'h30.
- Drop `ena` for 3 cycles mid-operation on 8'h7F+8'h01 → `done` at N+19; `sum`=8'h80, `cout`=0; outputs frozen while `ena`=0.
- Assert `rst_n`=0 at N+7 during 8'hFF+8'hFF → no `done`; `sum`=0, `cout`=0, state IDLE. A fresh start then gives `sum`=8'hFE, `cout`=1.
